// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO for the EX stage.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (MDOp 1xx); otherwise those codes are ignored.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q, b_q;
    logic [2:0]    op_q;

    logic        op_legal;
    logic        start_div;
    logic        is_div_q;
    logic        signed_q;
    logic [63:0] prod;
    logic [63:0] mresult;
    logic [31:0] div_a, div_b, quo_raw, rem_raw, quo, rem;

`ifdef MDU_MADD_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = ~MDOp[2];
`endif

    assign start_div = (MDOp[2:1] == 2'b01);
    assign is_div_q  = (op_q[2:1] == 2'b01);
    assign signed_q  = ~op_q[0];

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod = signed_q ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                           : ({32'b0, a_q} * {32'b0, b_q});

`ifdef MDU_MADD_EN
    always_comb begin
        mresult = prod;
        case (op_q[2:1])
            2'b10:   mresult = {HI, LO} + prod;
            2'b11:   mresult = {HI, LO} - prod;
            default: mresult = prod;
        endcase
    end
`else
    assign mresult = prod;
`endif

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
    assign div_a   = (signed_q && a_q[31]) ? -a_q : a_q;
    assign div_b   = (signed_q && b_q[31]) ? -b_q : b_q;
    assign quo_raw = div_a / div_b;
    assign rem_raw = div_a % div_b;
    assign quo     = (signed_q && (a_q[31] ^ b_q[31])) ? -quo_raw : quo_raw;
    assign rem     = (signed_q && a_q[31]) ? -rem_raw : rem_raw;

    // Start is a one-cycle launch pulse accepted only in IDLE with a legal MDOp;
    // Busy is high exactly while in RUN, and Start/HIWrite/LOWrite are ignored then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
        end else if (state == IDLE) begin
            if (Start && op_legal) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= MDOp;
                cnt   <= start_div ? DIV_LOAD : MULT_LOAD;
                state <= RUN;
                Busy  <= 1'b1;
            end else if (!Start) begin
                if (HIWrite) HI <= A;
                if (LOWrite) LO <= A;
            end
        end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                state <= IDLE;
                Busy  <= 1'b0;
                if (is_div_q) begin
                    if (b_q != 32'b0) begin
                        HI <= rem;
                        LO <= quo;
                    end
                end else begin
                    {HI, LO} <= mresult;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops against an arithmetic reference model.
module tb_mdu;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, Start, HIWrite, LOWrite, Busy;
  logic [2:0]  MDOp;
  logic [31:0] A, B, HI, LO;

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .Busy(Busy), .HI(HI), .LO(LO)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: {HI,LO} after op, from plain 64-bit / 32-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint          sp;
    longint unsigned up;
    logic [63:0]     p;
    int              sa, sb;
    sp = longint'($signed(a)) * longint'($signed(b));
    up = {32'b0, a} * {32'b0, b};
    p  = op[0] ? 64'(up) : 64'(sp);
    sa = a;
    sb = b;
    case (op)
      3'd0, 3'd1: return p;
      3'd2: begin
        if (b == 32'd0) return {hi, lo};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      3'd4, 3'd5: return {hi, lo} + p;
      default:    return {hi, lo} - p;
    endcase
  endfunction

  // driver: mthi/mtlo
  task automatic mt(input bit hw, input bit lw, input logic [31:0] a);
    @(negedge clk);
    HIWrite = hw; LOWrite = lw; A = a;
    check("mf_same_cycle_old", {HI, LO}, {m_hi, m_lo});
    @(negedge clk);
    HIWrite = 1'b0; LOWrite = 1'b0;
    if (hw) m_hi = a;
    if (lw) m_lo = a;
    check("mt_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  // driver: launch an op and follow it to completion.
  // poke: 0 none, 1 Start+mthi/mtlo mid-run, 2 reset at busy cycle 4,
  //       3 Start on the last busy cycle, 4 mthi/mtlo in the launch cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int poke);
    bit legal;
    int n;
    int busy_cycles;
    legal = MADD_EN || !op[2];
    n = (op[2:1] == 2'b01) ? DIV_CYCLES : MULT_CYCLES;
    busy_cycles = 0;
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    if (poke == 4) begin HIWrite = 1'b1; LOWrite = 1'b1; end
    if (legal) exp_q.push_back(model(op, a, b, m_hi, m_lo));
    @(negedge clk);
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    A = $urandom; B = $urandom;
    if (!legal) begin
      check("illegal_busy", 64'(Busy), 64'd0);
      check("illegal_hilo", {HI, LO}, {m_hi, m_lo});
      return;
    end
    check("run_hilo_pre", {HI, LO}, {m_hi, m_lo});
    while (Busy && busy_cycles < 4 * DIV_CYCLES) begin
      busy_cycles++;
      if (poke == 1 && busy_cycles == 2) begin
        Start = 1'b1; MDOp = 3'b000; HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hAAAA; B = 32'd3;
      end else if (poke == 3 && busy_cycles == n) begin
        Start = 1'b1; MDOp = 3'b001; A = 32'd7; B = 32'd9;
      end else if (poke == 2 && busy_cycles == 4) begin
        reset = 1'b1;
      end else begin
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; reset = 1'b0;
      end
      @(negedge clk);
      if (poke == 2 && busy_cycles == 4) break;
    end
    Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; reset = 1'b0;
    if (poke == 2) begin
      void'(exp_q.pop_back());
      m_hi = '0; m_lo = '0;
      check("reset_abort_busy", 64'(Busy), 64'd0);
      check("reset_abort_hilo", {HI, LO}, 64'd0);
      return;
    end
    check("busy_cycles", 64'(busy_cycles), 64'(n));
    {m_hi, m_lo} = exp_q.pop_front();
    check("result_hilo", {HI, LO}, {m_hi, m_lo});
  endtask

  logic [63:0] madd_exp;

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = '0; A = '0; B = '0; HIWrite = 1'b0; LOWrite = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    check("tp_mult", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    check("tp_multu", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("tp_div", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    mt(1'b1, 1'b0, 32'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    run_op(3'd3, 32'hDEAD_BEEF, 32'd0, 0);
    check("tp_divu_by_zero", {HI, LO}, 64'h0000_1234_0000_5678);

    run_op(3'd2, 32'd100, 32'd7, 1);
    check("tp_div_ignores_pokes", {HI, LO}, 64'h0000_0002_0000_000E);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3);
    check("tp_div_overflow", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(3'd2, 32'd12345, 32'd3, 2);

    mt(1'b1, 1'b1, 32'h0BAD_F00D);
    run_op(3'd1, 32'd3, 32'd4, 4);
    check("tp_start_drops_mt", {HI, LO}, 64'd12);

    mt(1'b1, 1'b0, 32'h0);
    mt(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd1, 32'd1, 0);
    madd_exp = MADD_EN ? 64'h0000_0001_0000_0000 : 64'h0000_0000_FFFF_FFFF;
    check("tp_maddu", {HI, LO}, madd_exp);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      int sel;
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 4));
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
